// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point mantissa datapaths: default
// mantissa width, derived product width and the sequencer state encoding.
package fp_pkg;

    // Mantissa width including the hidden bit.
    localparam int MANT_W_DEF = 24;

    // Full double-width product of two mantissas.
    localparam int PROD_W_DEF = 2 * MANT_W_DEF;

    // Sequencer states shared by the one-bit-per-cycle mantissa units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : fp_pkg

// File: rtl/onebit_mul_step.sv
// One radix-2 shift-add multiplication step: conditionally add the
// multiplicand into the upper accumulator half, then shift the whole
// {carry, acc_hi, p_lo} word right by one bit.
module onebit_mul_step
    import fp_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic [MANT_W-1:0] i_multiplicand,
    input  logic [MANT_W-1:0] i_acc_hi,
    input  logic [MANT_W-1:0] i_p_lo,
    output logic [MANT_W-1:0] o_acc_hi,
    output logic [MANT_W-1:0] o_p_lo
);

    logic [MANT_W-1:0] w_addend;
    logic [MANT_W:0]   w_sum;

    // Add-then-shift; the carry out of the add becomes the new MSB.
    always_comb begin
        w_addend = {MANT_W{1'b0}};
        if (i_p_lo[0]) begin
            w_addend = i_multiplicand;
        end else begin
            w_addend = {MANT_W{1'b0}};
        end
        w_sum    = {1'b0, i_acc_hi} + {1'b0, w_addend};
        o_acc_hi = w_sum[MANT_W:1];
        o_p_lo   = {w_sum[0], i_p_lo[MANT_W-1:1]};
    end

endmodule : onebit_mul_step

// File: rtl/fp_mant_mul_seq.sv
// Sequential radix-2 mantissa multiplier. Retires one multiplier bit per
// cycle, then publishes the raw product together with a normalised
// mantissa and guard/round/sticky bits for the rounder.
module fp_mant_mul_seq
    import fp_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_start,
    input  logic [MANT_W-1:0]     in_multiplicand,
    input  logic [MANT_W-1:0]     in_multiplier,
    output logic                  out_busy,
    output logic                  out_done,
    output logic [2*MANT_W-1:0]   out_product,
    output logic [MANT_W-1:0]     out_mant,
    output logic                  out_norm,
    output logic                  out_guard,
    output logic                  out_round,
    output logic                  out_sticky
);

    localparam int PROD_W = 2 * MANT_W;
    localparam int CNT_W  = $clog2(MANT_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MANT_W - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                w_load;
    logic                w_step;
    logic                w_last;

    logic [MANT_W-1:0]   r_a;
    logic [MANT_W-1:0]   r_acc;
    logic [MANT_W-1:0]   r_plo;
    logic [CNT_W-1:0]    r_cnt;
    logic [MANT_W-1:0]   w_acc_nxt;
    logic [MANT_W-1:0]   w_plo_nxt;
    logic [PROD_W-1:0]   w_prod_nxt;

    logic [MANT_W-1:0]   w_mant;
    logic                w_norm;
    logic                w_guard;
    logic                w_round;
    logic                w_sticky;

    logic                r_busy;
    logic                r_done;
    logic [PROD_W-1:0]   r_product;
    logic [MANT_W-1:0]   r_mant;
    logic                r_norm;
    logic                r_guard;
    logic                r_round;
    logic                r_sticky;

    onebit_mul_step #(
        .MANT_W         (MANT_W)
    ) u_step (
        .i_multiplicand (r_a),
        .i_acc_hi       (r_acc),
        .i_p_lo         (r_plo),
        .o_acc_hi       (w_acc_nxt),
        .o_p_lo         (w_plo_nxt)
    );

    // Sequencer state register.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_cnt == LAST_STEP) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, accumulator/multiplier shift register and step counter.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_a   <= {MANT_W{1'b0}};
            r_acc <= {MANT_W{1'b0}};
            r_plo <= {MANT_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_load) begin
            r_a   <= in_multiplicand;
            r_acc <= {MANT_W{1'b0}};
            r_plo <= in_multiplier;
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_step) begin
            r_acc <= w_acc_nxt;
            r_plo <= w_plo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_a   <= r_a;
            r_acc <= r_acc;
            r_plo <= r_plo;
            r_cnt <= r_cnt;
        end
    end

    // Normalise the product produced by the final step: pick the mantissa
    // window by the product MSB and collect the bits below it.
    always_comb begin
        w_prod_nxt = {w_acc_nxt, w_plo_nxt};
        w_norm     = 1'b0;
        w_mant     = {MANT_W{1'b0}};
        w_guard    = 1'b0;
        w_round    = 1'b0;
        w_sticky   = 1'b0;
        if (w_prod_nxt[PROD_W-1]) begin
            w_norm   = 1'b1;
            w_mant   = w_prod_nxt[PROD_W-1:MANT_W];
            w_guard  = w_prod_nxt[MANT_W-1];
            w_round  = w_prod_nxt[MANT_W-2];
            w_sticky = |w_prod_nxt[MANT_W-3:0];
        end else begin
            w_norm   = 1'b0;
            w_mant   = w_prod_nxt[PROD_W-2:MANT_W-1];
            w_guard  = w_prod_nxt[MANT_W-2];
            w_round  = w_prod_nxt[MANT_W-3];
            w_sticky = |w_prod_nxt[MANT_W-4:0];
        end
    end

    // Result registers: loaded on the last step so they are valid with done,
    // and held until the next completion or reset.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_product <= {PROD_W{1'b0}};
            r_mant    <= {MANT_W{1'b0}};
            r_norm    <= 1'b0;
            r_guard   <= 1'b0;
            r_round   <= 1'b0;
            r_sticky  <= 1'b0;
        end else if (w_last) begin
            r_product <= w_prod_nxt;
            r_mant    <= w_mant;
            r_norm    <= w_norm;
            r_guard   <= w_guard;
            r_round   <= w_round;
            r_sticky  <= w_sticky;
        end else begin
            r_product <= r_product;
            r_mant    <= r_mant;
            r_norm    <= r_norm;
            r_guard   <= r_guard;
            r_round   <= r_round;
            r_sticky  <= r_sticky;
        end
    end

    // Status flags: busy follows the next state, done pulses in the DONE cycle.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= w_last;
        end
    end

    assign out_busy    = r_busy;
    assign out_done    = r_done;
    assign out_product = r_product;
    assign out_mant    = r_mant;
    assign out_norm    = r_norm;
    assign out_guard   = r_guard;
    assign out_round   = r_round;
    assign out_sticky  = r_sticky;

endmodule : fp_mant_mul_seq

// File: tb/tb_fp_mant_mul_seq.sv
// Bench for fp_mant_mul_seq: directed operations with hand-computed results,
// plus a cycle-level reference model compared against the outputs every cycle.
module tb_fp_mant_mul_seq;

    localparam int W = 24;

    typedef struct packed {
        logic [2*W-1:0] prod;
        logic [W-1:0]   mant;
        logic           norm;
        logic           g;
        logic           r;
        logic           s;
    } res_t;

    logic           in_clk = 1'b0;
    logic           in_rst;
    logic           in_start;
    logic [W-1:0]   in_multiplicand;
    logic [W-1:0]   in_multiplier;
    logic           out_busy;
    logic           out_done;
    logic [2*W-1:0] out_product;
    logic [W-1:0]   out_mant;
    logic           out_norm;
    logic           out_guard;
    logic           out_round;
    logic           out_sticky;

    int total = 0;
    int bad   = 0;

    fp_mant_mul_seq #(.MANT_W(W)) dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_start        (in_start),
        .in_multiplicand (in_multiplicand),
        .in_multiplier   (in_multiplier),
        .out_busy        (out_busy),
        .out_done        (out_done),
        .out_product     (out_product),
        .out_mant        (out_mant),
        .out_norm        (out_norm),
        .out_guard       (out_guard),
        .out_round       (out_round),
        .out_sticky      (out_sticky)
    );

    // Free-running clock.
    always #5 in_clk = ~in_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, then window selection by magnitude.
    function automatic res_t ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t            res;
        longint unsigned p;
        longint unsigned low;
        int              sh;
        p        = longint'(a) * longint'(b);
        res.prod = p[2*W-1:0];
        res.norm = (p >= (64'd1 << (2*W-1)));
        sh       = res.norm ? W : W - 1;
        res.mant = W'(p >> sh);
        low      = p & ((64'd1 << sh) - 64'd1);
        res.g    = low[sh-1];
        res.r    = low[sh-2];
        res.s    = (low & ((64'd1 << (sh-2)) - 64'd1)) != 64'd0;
        return res;
    endfunction

    // Cycle model: an accepted start occupies the next W+1 cycles, the last
    // of which is the done cycle carrying the new result.
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    int           m_left = 0;
    logic         e_busy = 1'b0;
    logic         e_done = 1'b0;
    res_t         e_res  = '0;

    always @(posedge in_clk) begin
        if (in_rst) begin
            e_busy = 1'b0;
            e_done = 1'b0;
            m_left = 0;
            e_res  = '0;
        end else begin
            e_done = 1'b0;
            if (!e_busy) begin
                if (in_start) begin
                    m_a    = in_multiplicand;
                    m_b    = in_multiplier;
                    e_busy = 1'b1;
                    m_left = W + 1;
                end
            end else if (m_left == 1) begin
                e_busy = 1'b0;
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 1) begin
                    e_done = 1'b1;
                    e_res  = ref_mul(m_a, m_b);
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge in_clk) begin
        chk("m_busy",    64'(out_busy),    64'(e_busy));
        chk("m_done",    64'(out_done),    64'(e_done));
        chk("m_product", 64'(out_product), 64'(e_res.prod));
        chk("m_mant",    64'(out_mant),    64'(e_res.mant));
        chk("m_norm",    64'(out_norm),    64'(e_res.norm));
        chk("m_guard",   64'(out_guard),   64'(e_res.g));
        chk("m_round",   64'(out_round),   64'(e_res.r));
        chk("m_sticky",  64'(out_sticky),  64'(e_res.s));
    end

    // One operation started in cycle 0; checks latency and literal results.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] xp, input logic [W-1:0] xm,
                          input logic xn, input logic xg, input logic xr, input logic xs);
        int n;
        @(posedge in_clk); #1;
        in_start        = 1'b1;
        in_multiplicand = a;
        in_multiplier   = b;
        @(posedge in_clk); #1;
        in_start        = 1'b0;
        in_multiplicand = ~a;
        in_multiplier   = ~b;
        n = 1;
        while (n <= 40) begin
            @(negedge in_clk);
            if (out_done === 1'b1) break;
            n++;
            @(posedge in_clk); #1;
        end
        chk({name, "_latency"}, 64'(n),           64'd25);
        chk({name, "_busy"},    64'(out_busy),    64'd1);
        chk({name, "_product"}, 64'(out_product), 64'(xp));
        chk({name, "_mant"},    64'(out_mant),    64'(xm));
        chk({name, "_norm"},    64'(out_norm),    64'(xn));
        chk({name, "_guard"},   64'(out_guard),   64'(xg));
        chk({name, "_round"},   64'(out_round),   64'(xr));
        chk({name, "_sticky"},  64'(out_sticky),  64'(xs));
    endtask

    initial begin
        res_t r;
        int   n;
        int   done1;
        int   done2;
        int   ndone;

        in_rst          = 1'b1;
        in_start        = 1'b0;
        in_multiplicand = '0;
        in_multiplier   = '0;

        // Pin the reference model on hand-computed values.
        r = ref_mul(24'hFFFFFF, 24'hFFFFFF);
        chk("ref_ff_prod",   64'(r.prod), 64'hFFFFFE000001);
        chk("ref_ff_mant",   64'(r.mant), 64'hFFFFFE);
        chk("ref_ff_sticky", 64'(r.s),    64'd1);
        r = ref_mul(24'h800000, 24'h800000);
        chk("ref_80_mant",   64'(r.mant), 64'h800000);
        chk("ref_80_norm",   64'(r.norm), 64'd0);
        r = ref_mul(24'h400000, 24'h000001);
        chk("ref_40_guard",  64'(r.g),    64'd1);

        repeat (3) @(posedge in_clk);
        #1 in_rst = 1'b0;
        @(negedge in_clk);
        chk("rst_busy",    64'(out_busy),    64'd0);
        chk("rst_done",    64'(out_done),    64'd0);
        chk("rst_product", 64'(out_product), 64'd0);
        chk("rst_mant",    64'(out_mant),    64'd0);

        run_op("one_x_one", 24'h800000, 24'h800000, 48'h400000000000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("max_sq",    24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 24'hFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("c0_sq",     24'hC00000, 24'hC00000, 48'h900000000000, 24'h900000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("zero_a",    24'h000000, 24'h123456, 48'h000000000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("tiny_g",    24'h400000, 24'h000001, 48'h000000400000, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("tiny_s",    24'h000003, 24'h000005, 48'h00000000000F, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Start held high: second op must be accepted the cycle after done.
        @(posedge in_clk); #1;
        in_start        = 1'b1;
        in_multiplicand = 24'hC00000;
        in_multiplier   = 24'hC00000;
        n     = 0;
        done1 = -1;
        done2 = -1;
        while (n < 56) begin
            @(negedge in_clk);
            if (out_done === 1'b1) begin
                if (done1 < 0) done1 = n;
                else if (done2 < 0) done2 = n;
            end
            if (n == 40) chk("b2b_hold_product", 64'(out_product), 64'h900000000000);
            @(posedge in_clk); #1;
            n++;
            if (n == 1) begin
                in_multiplicand = 24'hFFFFFF;
                in_multiplier   = 24'hFFFFFF;
            end
            if (n == 27) in_start = 1'b0;
        end
        chk("b2b_done1",   64'(done1),       64'd25);
        chk("b2b_done2",   64'(done2),       64'd51);
        chk("b2b_product", 64'(out_product), 64'hFFFFFE000001);

        // Reset in cycle 10 aborts the operation and clears the outputs.
        @(posedge in_clk); #1;
        in_start        = 1'b1;
        in_multiplicand = 24'hC00000;
        in_multiplier   = 24'hC00000;
        n = 0;
        while (n < 10) begin
            @(posedge in_clk); #1;
            in_start = 1'b0;
            n++;
        end
        in_rst = 1'b1;
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        @(negedge in_clk);
        chk("abort_busy",    64'(out_busy),    64'd0);
        chk("abort_done",    64'(out_done),    64'd0);
        chk("abort_product", 64'(out_product), 64'd0);
        chk("abort_mant",    64'(out_mant),    64'd0);
        chk("abort_norm",    64'(out_norm),    64'd0);
        chk("abort_sticky",  64'(out_sticky),  64'd0);
        ndone = 0;
        repeat (30) begin
            @(negedge in_clk);
            if (out_done === 1'b1) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        run_op("after_rst", 24'h800000, 24'h800000, 48'h400000000000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge in_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fp_mant_mul_seq

// File: doc/fp_mant_mul_seq.md
Name: fp_mant_mul_seq

Overview:
Sequential radix-2 shift-add mantissa multiplier for the FP_Mul path. It is the multiplicative counterpart of the FP_Div one-bit restoring-division datapath and retires one multiplier bit per cycle. It takes two MANT_W-bit mantissas with the hidden bit included and returns the 2*MANT_W-bit product. It also returns a normalised mantissa plus guard/round/sticky bits for the downstream rounder.

Parameters:
MANT_W, 24, mantissa width including hidden bit; product width is 2*MANT_W.

Ports:
in_clk  input  1  clock; all state updates on the rising edge.
in_rst  input  1  reset; synchronous, active-high.
in_start  input  1  start request; sampled only in IDLE.
in_multiplicand  input  MANT_W  operand A; captured when start is accepted.
in_multiplier  input  MANT_W  operand B; captured when start is accepted.
out_busy  output  1  high while an operation is in flight (CALC or DONE).
out_done  output  1  one-cycle pulse; result outputs are valid from this cycle.
out_product  output  2*MANT_W  raw product A*B.
out_mant  output  MANT_W  normalised product mantissa.
out_norm  output  1  1 if product >= 2.0 (exponent +1 required).
out_guard  output  1  first bit below out_mant.
out_round  output  1  second bit below out_mant.
out_sticky  output  1  OR of all remaining lower bits.

Behaviour:
- Reset: in_rst high at an edge forces state IDLE, counter 0, internal registers 0, and all outputs 0. Reset overrides any operation in flight.
- Reset mid-operation: the operation is aborted with no out_done pulse. The next start after reset runs normally.
- States and transitions:
  - IDLE: if in_start=1, capture A and B, clear the accumulator, clear the counter, go to CALC. Otherwise stay in IDLE.
  - CALC: one step per cycle, no early termination.
    - Add: {c, acc_hi} = acc_hi + (P[0] ? A : 0).
    - Shift: P = {c, acc_hi, P_lo} >> 1, where P_lo initially holds B.
    - After MANT_W steps go to DONE.
  - DONE: register the product and normalisation outputs, pulse out_done, go to IDLE.
- Latency: with in_start sampled in cycle 0, out_done is high in exactly cycle MANT_W+1 (cycle 25 by default). This is fixed for all operands, including zero.
- out_busy is high in cycles 1..MANT_W+1 and low in IDLE.
- in_start is ignored while out_busy=1, including in the DONE cycle. The earliest back-to-back start is the cycle after out_done.
- Result outputs hold their last values until the next DONE or reset. They are not cleared when a new start is accepted.
- Width rules: the accumulator is MANT_W+1 bits (carry kept). The product register is 2*MANT_W bits. No overflow can occur.
- Normalisation, when product bit P[2W-1]=1:
  - out_norm=1, out_mant=P[2W-1:W].
  - guard=P[W-1], round=P[W-2], sticky=|P[W-3:0].
- Normalisation, otherwise:
  - out_norm=0, out_mant=P[2W-2:W-1].
  - guard=P[W-2], round=P[W-3], sticky=|P[W-4:0].
- A zero operand gives an all-zero product, out_norm=0, and all-zero mant/guard/round/sticky.
- No assumption is made that hidden bits are set. Unnormalised inputs produce the exact product, and the normalisation rule above still applies.

Decomposition:
- Shared package fp_pkg holds:
  - MANT_W default (24);
  - the state encoding constants IDLE/CALC/DONE;
  - the product-width constant 2*MANT_W.
- Sub-module onebit_mul_step: combinational conditional add plus right shift of {carry, acc_hi, P_lo}. It mirrors the divider's one-bit step and is instantiated once.

Test Plan:
- A=0x800000, B=0x800000, start in cycle 0 -> out_done in cycle 25; product=0x400000000000, norm=0, mant=0x800000, g=r=s=0; busy high in cycles 1..25.
- A=B=0xFFFFFF -> product=0xFFFFFE000001, norm=1, mant=0xFFFFFE, guard=0, round=0, sticky=1.
- A=B=0xC00000 -> product=0x900000000000, norm=1, mant=0x900000, g=r=s=0.
- A=0x000000, B=0x123456 -> product=0, all flags 0; done still in cycle 25.
- Start held high continuously from cycle 0 -> second op accepted in cycle 26 (not 25), second done in cycle 51. Outputs hold the first result during cycles 26..50.
- in_rst pulsed in cycle 10 of an op -> cycle 11: busy=0, all outputs 0, no done pulse. A fresh op with A=B=0x800000 then completes correctly.
